// File: rtl/fetch_queue_unit.sv
// Fetch stage: serves PCs from a one-line instruction buffer, refills the line on a miss,
// and queues {pc, instruction} pairs in a small FIFO for decode.
module fetch_queue_unit #(
    parameter int XLEN        = 32,
    parameter int ILEN        = 32,
    parameter int LINE_WORDS  = 4,
    parameter int QUEUE_DEPTH = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_n_i,
    input  logic                               flush_i,
    input  logic [XLEN-1:0]                    pc_i,
    input  logic                               pc_valid_i,
    output logic                               fetch_ready_o,
    output logic                               read_req_o,
    output logic [XLEN-1:0]                    read_addr_o,
    input  logic [LINE_WORDS*ILEN-1:0]         read_line_i,
    input  logic                               read_done_i,
    input  logic                               issue_ready_i,
    output logic                               issue_valid_o,
    output logic [ILEN-1:0]                    instruction_o,
    output logic [XLEN-1:0]                    issue_pc_o,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_count_o
);

    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int LB    = IDX_W + 2;
    localparam int TAG_W = XLEN - LB;
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(QUEUE_DEPTH);

    typedef enum logic [1:0] {RUN, MISS, DRAIN} state_t;

    state_t                         state, state_next;
    logic [LINE_WORDS-1:0][ILEN-1:0] line_reg;
    logic [TAG_W-1:0]               line_tag;
    logic                           line_valid;
    logic                           hit, push, pop, capture;
    logic [ILEN-1:0]                pc_word;
    logic [PTR_W-1:0]               wr_ptr, rd_ptr;
    logic [CNT_W-1:0]               count;
    logic [XLEN-1:0]                q_pc    [QUEUE_DEPTH];
    logic [ILEN-1:0]                q_instr [QUEUE_DEPTH];
    logic                           unused_bits;

    assign hit         = line_valid && (pc_i[XLEN-1:LB] == line_tag);
    assign pc_word     = line_reg[pc_i[LB-1:2]];
    assign unused_bits = ^pc_i[1:0];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= RUN;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (pc_valid_i && !hit && !flush_i) state_next = MISS;
            MISS:    if (read_done_i) state_next = RUN;
                     else if (flush_i) state_next = DRAIN;
            DRAIN:   if (read_done_i) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // A flush in the same cycle as the refill data still keeps the line.
    always_comb begin
        fetch_ready_o = 1'b0;
        capture       = 1'b0;
        case (state)
            RUN:     fetch_ready_o = hit && (count < FULL) && !flush_i;
            MISS:    capture = read_done_i;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            read_req_o  <= 1'b0;
            read_addr_o <= '0;
        end else begin
            read_req_o <= (state_next == MISS);
            if (state == RUN && state_next == MISS)
                read_addr_o <= {pc_i[XLEN-1:LB], {LB{1'b0}}};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            line_reg   <= '0;
            line_tag   <= '0;
            line_valid <= 1'b0;
        end else if (capture) begin
            line_reg   <= read_line_i;
            line_tag   <= read_addr_o[XLEN-1:LB];
            line_valid <= 1'b1;
        end
    end

    assign push          = fetch_ready_o && pc_valid_i;
    assign issue_valid_o = (count != '0);
    assign pop           = issue_valid_o && issue_ready_i && !flush_i;

    // Storage is reset so the head outputs are never X, even when empty.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q_pc[i]    <= '0;
                q_instr[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                q_pc[wr_ptr]    <= pc_i;
                q_instr[wr_ptr] <= pc_word;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign instruction_o = q_instr[rd_ptr];
    assign issue_pc_o    = q_pc[rd_ptr];
    assign queue_count_o = count;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: a queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_fetch_queue_unit;

    logic         clk = 1'b0, rst_n = 1'b1, flush = 1'b0, pc_valid = 1'b0;
    logic         read_done = 1'b0, issue_ready = 1'b0;
    logic [31:0]  pc_in = '0;
    logic [127:0] read_line = '0;
    logic         fetch_ready, read_req, issue_valid;
    logic [31:0]  read_addr, instruction, issue_pc;
    logic [3:0]   queue_count;

    fetch_queue_unit #(.XLEN(32), .ILEN(32), .LINE_WORDS(4), .QUEUE_DEPTH(8)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .pc_i(pc_in), .pc_valid_i(pc_valid),
        .fetch_ready_o(fetch_ready), .read_req_o(read_req), .read_addr_o(read_addr),
        .read_line_i(read_line), .read_done_i(read_done), .issue_ready_i(issue_ready),
        .issue_valid_o(issue_valid), .instruction_o(instruction), .issue_pc_o(issue_pc),
        .queue_count_o(queue_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: the line buffer, a refill mode and a plain queue of entries.
    typedef struct packed { logic [31:0] pc; logic [31:0] ins; } entry_t;
    entry_t      mq[$];
    entry_t      e;
    logic        m_valid;
    logic [27:0] m_tag;
    logic [31:0] m_line [4];
    int          m_wait;    // 0 idle, 1 awaiting refill, 2 discarding refill
    logic        m_req;
    logic [31:0] m_addr;
    logic        do_push, do_pop, m_hit_now;

    function automatic logic m_hit();
        return m_valid && (pc_in[31:4] == m_tag);
    endfunction

    function automatic logic m_fr();
        return (m_wait == 0) && m_hit() && (mq.size() < 8) && !flush;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_fetch_ready", fetch_ready, 0);
            chk("rst_read_req", read_req, 0);
            chk("rst_read_addr", read_addr, 0);
            chk("rst_issue_valid", issue_valid, 0);
            chk("rst_count", queue_count, 0);
            chk("rst_instr", instruction, 0);
            chk("rst_issue_pc", issue_pc, 0);
            mq.delete();
            m_valid = 1'b0; m_tag = '0; m_wait = 0; m_req = 1'b0; m_addr = '0;
            for (int i = 0; i < 4; i++) m_line[i] = '0;
        end else begin
            chk("m_fetch_ready", fetch_ready, m_fr());
            chk("m_read_req", read_req, m_req);
            chk("m_read_addr", read_addr, m_addr);
            chk("m_issue_valid", issue_valid, mq.size() > 0);
            chk("m_count", queue_count, mq.size());
            if (mq.size() > 0) begin
                chk("m_instr", instruction, mq[0].ins);
                chk("m_issue_pc", issue_pc, mq[0].pc);
            end
            // advance to the state after the coming rising edge
            m_hit_now = m_hit();
            do_push   = m_fr() && pc_valid;
            do_pop    = (mq.size() > 0) && issue_ready && !flush;
            if (flush) mq.delete();
            else begin
                if (do_pop) void'(mq.pop_front());
                if (do_push) begin
                    e.pc  = pc_in;
                    e.ins = m_line[pc_in[3:2]];
                    mq.push_back(e);
                end
            end
            case (m_wait)
                0: if (pc_valid && !m_hit_now && !flush) begin
                       m_wait = 1; m_req = 1'b1; m_addr = {pc_in[31:4], 4'h0};
                   end
                1: if (read_done) begin
                       for (int i = 0; i < 4; i++) m_line[i] = read_line[32*i +: 32];
                       m_tag = m_addr[31:4]; m_valid = 1'b1; m_wait = 0; m_req = 1'b0;
                   end else if (flush) begin
                       m_wait = 2; m_req = 1'b0;
                   end
                default: if (read_done) m_wait = 0;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [127:0] L100 = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    localparam logic [127:0] L110 = {32'h44440113, 32'h33330112, 32'h22220111, 32'h11110110};
    localparam logic [127:0] L200 = {32'h00002003, 32'h00002002, 32'h00002001, 32'h00002000};
    localparam logic [127:0] L300 = {32'h00003003, 32'h00003002, 32'h00003001, 32'h00003000};
    localparam logic [127:0] LJNK = {4{32'hDEADBEEF}};

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) step();
        chk("reset_req", read_req, 0);
        chk("reset_valid", issue_valid, 0);
        chk("reset_count", queue_count, 0);
        chk("reset_ready", fetch_ready, 0);

        // first miss and refill
        rst_n = 1'b1; pc_in = 32'h100; pc_valid = 1'b1; issue_ready = 1'b1;
        step();
        chk("miss_req", read_req, 1);
        chk("miss_addr", read_addr, 32'h100);
        chk("miss_ready", fetch_ready, 0);
        step(); step();
        read_line = L100; read_done = 1'b1;
        step();
        read_done = 1'b0;
        chk("refill_ready", fetch_ready, 1);
        step();
        chk("first_valid", issue_valid, 1);
        chk("first_instr", instruction, 32'hAAAA0000);
        chk("first_pc", issue_pc, 32'h100);

        // sequential hits, back-to-back
        pc_in = 32'h104; step(); chk("seq_b", instruction, 32'hBBBB0001);
        pc_in = 32'h108; step(); chk("seq_c", instruction, 32'hCCCC0002);
        pc_in = 32'h10C; step(); chk("seq_d", instruction, 32'hDDDD0003);
        chk("seq_no_req", read_req, 0);
        pc_in = 32'h110; step();
        chk("next_line_req", read_req, 1);
        chk("next_line_addr", read_addr, 32'h110);
        step();
        read_line = L110; read_done = 1'b1;
        step();
        read_done = 1'b0; issue_ready = 1'b0;

        // fill to full, then drain across pointer wrap
        for (int i = 0; i < 8; i++) begin
            pc_in = 32'h110 + 32'(4 * (i % 4));
            step();
        end
        pc_in = 32'h110; #1;
        chk("full_count", queue_count, 8);
        chk("full_ready", fetch_ready, 0);
        pc_valid = 1'b0; issue_ready = 1'b1;
        repeat (8) step();
        chk("drained_count", queue_count, 0);

        // count held at 3 under simultaneous push/pop
        issue_ready = 1'b0; pc_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc_in = 32'h110 + 32'(4 * i);
            step();
        end
        chk("pp_pre", queue_count, 3);
        issue_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pc_in = 32'h110 + 32'(4 * ((i + 3) % 4));
            step();
        end
        chk("pp_count", queue_count, 3);
        pc_valid = 1'b0;
        repeat (3) step();

        // flush during refill, late data discarded
        pc_in = 32'h200; pc_valid = 1'b1;
        step();
        chk("drain_miss_addr", read_addr, 32'h200);
        flush = 1'b1;
        step();
        flush = 1'b0; pc_valid = 1'b0;
        chk("drain_req", read_req, 0);
        repeat (3) step();
        read_line = LJNK; read_done = 1'b1;
        step();
        read_done = 1'b0;
        pc_in = 32'h114; pc_valid = 1'b1; #1;
        chk("post_drain_hit", fetch_ready, 1);
        step();
        chk("line_kept", instruction, 32'h22220111);
        pc_in = 32'h200;
        step();
        chk("refetch_req", read_req, 1);
        read_line = L200; read_done = 1'b1;
        step();
        read_done = 1'b0;
        chk("refetch_ready", fetch_ready, 1);
        step();
        chk("refetch_instr", instruction, 32'h00002000);
        pc_valid = 1'b0;
        step();

        // flush together with refill data: line kept
        pc_in = 32'h300; pc_valid = 1'b1;
        step();
        pc_valid = 1'b0; flush = 1'b1; read_line = L300; read_done = 1'b1;
        step();
        flush = 1'b0; read_done = 1'b0; pc_in = 32'h308; pc_valid = 1'b1; #1;
        chk("flush_done_capture", fetch_ready, 1);

        // flush a 5-entry queue while decode is ready
        issue_ready = 1'b0;
        repeat (5) step();
        chk("five_count", queue_count, 5);
        flush = 1'b1; issue_ready = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_valid", issue_valid, 0);
        chk("flush_count", queue_count, 0);
        pc_in = 32'h304; #1;
        chk("redirect_hit", fetch_ready, 1);
        step();
        chk("redirect_no_req", read_req, 0);
        chk("redirect_instr", instruction, 32'h00003001);

        // reset in the middle of a refill
        pc_in = 32'h400;
        step();
        chk("mid_miss_req", read_req, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_req", read_req, 0);
        chk("async_addr", read_addr, 0);
        chk("async_count", queue_count, 0);
        pc_valid = 1'b0;
        step();
        rst_n = 1'b1;
        read_line = L100; read_done = 1'b1;
        step();
        read_done = 1'b0;
        chk("stray_done_req", read_req, 0);
        pc_in = 32'h100; pc_valid = 1'b1; #1;
        chk("no_line_after_reset", fetch_ready, 0);
        step();
        chk("after_reset_miss", read_req, 1);
        pc_valid = 1'b0;
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
